generador_direccion_escalado: RTL and testbench

Parametrised successor to the VGA frame-buffer address counter. It converts the sync generator's pixel coordinates into a linear read address for an image of IMG_W×IMG_H pixels placed at (X0, Y0). Each stored pixel is replicated SCALE×SCALE on screen, and the block supplies a validity strobe delayed by the memory read latency. It sits between the VGA sync generator and the frame-buffer RAM.

---
 rtl/generador_direccion_escalado.sv | 136 +++++++++++++
 tb/tb_generador_direccion_escalado.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/generador_direccion_escalado.sv
// Frame-buffer read address generator for a scaled image window.
// Each stored pixel covers SCALE x SCALE screen pixels; no divider is used.
module generador_direccion_escalado #(
  parameter int unsigned X0      = 20,
  parameter int unsigned Y0      = 40,
  parameter int unsigned IMG_W   = 100,
  parameter int unsigned IMG_H   = 100,
  parameter int unsigned SCALE   = 4,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              data_valid,
  output logic              frame_start
);

  localparam int unsigned WIN_W = IMG_W * SCALE;
  localparam int unsigned WIN_H = IMG_H * SCALE;
  localparam int unsigned X_END = X0 + WIN_W - 1;
  localparam int unsigned SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'(SCALE - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(IMG_W);

  logic [31:0] xi;
  logic [31:0] yi;
  logic        in_rows;
  logic        in_cols;
  logic        in_win;
  logic        origin;
  logic        win_start;
  logic        last_px;

  logic [SUB_W-1:0]  sub_x, sub_x_n;
  logic [SUB_W-1:0]  sub_y, sub_y_n;
  logic [COL_W-1:0]  col, col_n;
  logic [ADDR_W-1:0] line_base, line_base_n;
  logic [ADDR_W-1:0] addr_n;

  // Unsigned offset compares: a coordinate below the origin wraps to a huge value
  assign xi        = 32'(x);
  assign yi        = 32'(y);
  assign in_rows   = (yi - Y0) < WIN_H;
  assign in_cols   = (xi - X0) < WIN_W;
  assign in_win    = in_rows && in_cols;
  assign origin    = (x == 10'd0) && (y == 10'd0);
  assign win_start = in_rows && (xi == X0);
  assign last_px   = in_rows && (xi == X_END);

  // Next-state of the position counters and the address
  always_comb begin
    sub_x_n     = sub_x;
    sub_y_n     = sub_y;
    col_n       = col;
    line_base_n = line_base;
    addr_n      = addr;

    if (origin) begin
      sub_x_n     = '0;
      col_n       = '0;
      sub_y_n     = '0;
      line_base_n = '0;
    end

    if (win_start) begin
      sub_x_n = '0;
      col_n   = '0;
      addr_n  = line_base_n;
    end else if (in_win) begin
      if (sub_x == SUB_MAX) begin
        sub_x_n = '0;
        col_n   = col + COL_W'(1);
      end else begin
        sub_x_n = sub_x + SUB_W'(1);
      end
      addr_n = line_base_n + ADDR_W'(col_n);
    end

    // Row advance happens after the last pixel's address was formed
    if (last_px) begin
      if (sub_y_n == SUB_MAX) begin
        sub_y_n     = '0;
        line_base_n = line_base_n + LINE_STEP;
      end else begin
        sub_y_n = sub_y_n + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sub_x       <= '0;
      sub_y       <= '0;
      col         <= '0;
      line_base   <= '0;
      addr        <= '0;
      addr_valid  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sub_x       <= sub_x_n;
      sub_y       <= sub_y_n;
      col         <= col_n;
      line_base   <= line_base_n;
      addr        <= addr_n;
      addr_valid  <= in_win;
      frame_start <= origin;
    end
  end

  // addr_valid delayed to line up with the RAM read data
  if (LATENCY == 0) begin : g_no_lat
    assign data_valid = addr_valid;
  end else begin : g_lat
    logic [LATENCY-1:0] dv_sr;

    always_ff @(posedge clk) begin
      if (reset) begin
        dv_sr <= '0;
      end else begin
        dv_sr[0] <= addr_valid;
        for (int i = 1; i < int'(LATENCY); i++) begin
          dv_sr[i] <= dv_sr[i-1];
        end
      end
    end

    assign data_valid = dv_sr[LATENCY-1];
  end

endmodule

// File: tb/tb_generador_direccion_escalado.sv
// Scoreboard bench: four differently parameterised instances share one raster
// stimulus; expected outputs come from coordinate arithmetic in the model.
module tb_generador_direccion_escalado;

  localparam int NI = 4;
  localparam int P_X0 [NI] = '{20, 20, 20, 0};
  localparam int P_Y0 [NI] = '{40, 40, 40, 0};
  localparam int P_W  [NI] = '{100, 100, 400, 10};
  localparam int P_H  [NI] = '{3, 3, 12, 3};
  localparam int P_S  [NI] = '{4, 4, 1, 2};
  localparam int P_L  [NI] = '{1, 3, 1, 0};

  typedef struct packed {
    logic [NI-1:0][17:0] addr;
    logic [NI-1:0]       chk;
    logic [NI-1:0]       av;
    logic [NI-1:0]       dv;
    logic [NI-1:0]       fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] x;
  logic [9:0] y;

  logic [13:0] addr_a, addr_b;
  logic [17:0] addr_c;
  logic [4:0]  addr_d;
  logic [NI-1:0] av_o, dv_o, fs_o;
  logic [17:0] got_addr [NI];

  always #5 clk = ~clk;

  generador_direccion_escalado #(
    .X0(P_X0[0]), .Y0(P_Y0[0]), .IMG_W(P_W[0]), .IMG_H(P_H[0]),
    .SCALE(P_S[0]), .ADDR_W(14), .LATENCY(P_L[0])
  ) dut_a (
    .clk(clk), .reset(reset), .x(x), .y(y), .addr(addr_a),
    .addr_valid(av_o[0]), .data_valid(dv_o[0]), .frame_start(fs_o[0])
  );

  generador_direccion_escalado #(
    .X0(P_X0[1]), .Y0(P_Y0[1]), .IMG_W(P_W[1]), .IMG_H(P_H[1]),
    .SCALE(P_S[1]), .ADDR_W(14), .LATENCY(P_L[1])
  ) dut_b (
    .clk(clk), .reset(reset), .x(x), .y(y), .addr(addr_b),
    .addr_valid(av_o[1]), .data_valid(dv_o[1]), .frame_start(fs_o[1])
  );

  generador_direccion_escalado #(
    .X0(P_X0[2]), .Y0(P_Y0[2]), .IMG_W(P_W[2]), .IMG_H(P_H[2]),
    .SCALE(P_S[2]), .ADDR_W(18), .LATENCY(P_L[2])
  ) dut_c (
    .clk(clk), .reset(reset), .x(x), .y(y), .addr(addr_c),
    .addr_valid(av_o[2]), .data_valid(dv_o[2]), .frame_start(fs_o[2])
  );

  generador_direccion_escalado #(
    .X0(P_X0[3]), .Y0(P_Y0[3]), .IMG_W(P_W[3]), .IMG_H(P_H[3]),
    .SCALE(P_S[3]), .ADDR_W(5), .LATENCY(P_L[3])
  ) dut_d (
    .clk(clk), .reset(reset), .x(x), .y(y), .addr(addr_d),
    .addr_valid(av_o[3]), .data_valid(dv_o[3]), .frame_start(fs_o[3])
  );

  assign got_addr[0] = 18'(addr_a);
  assign got_addr[1] = 18'(addr_b);
  assign got_addr[2] = 18'(addr_c);
  assign got_addr[3] = 18'(addr_d);

  // Reference model state
  bit  synced    [NI];
  bit  ref_ok    [NI];
  int  ref_y     [NI];
  bit  known     [NI];
  int  last_addr [NI];
  int  since_rst [NI];
  logic [NI-1:0] av_hist [$];
  exp_t expq [$];

  int vectors;
  int miscompares;
  exp_t mon_e;

  // Drive one pixel and push what every instance must show after the next edge
  task automatic apply(input int xx, input int yy, input bit r);
    exp_t e;
    logic [NI-1:0] avv;
    @(negedge clk);
    x = 10'(xx);
    y = 10'(yy);
    reset = r;
    e = '0;
    avv = '0;
    for (int i = 0; i < NI; i++) begin
      bit in_rows;
      bit in_win;
      in_rows = (yy >= P_Y0[i]) && (yy < P_Y0[i] + P_H[i] * P_S[i]);
      in_win  = in_rows && (xx >= P_X0[i]) && (xx < P_X0[i] + P_W[i] * P_S[i]);
      if (r) begin
        synced[i]    = 1'b0;
        ref_ok[i]    = in_rows;
        ref_y[i]     = yy;
        known[i]     = 1'b1;
        last_addr[i] = 0;
        since_rst[i] = 0;
      end else begin
        if (since_rst[i] < 1000) since_rst[i]++;
        e.fs[i] = (xx == 0) && (yy == 0);
        if (e.fs[i]) synced[i] = 1'b1;
        avv[i] = in_win;
        if (in_win) begin
          if (synced[i]) begin
            last_addr[i] = ((yy - P_Y0[i]) / P_S[i]) * P_W[i] + (xx - P_X0[i]) / P_S[i];
            known[i] = 1'b1;
          end else if (ref_ok[i] && yy > ref_y[i]) begin
            // rows restart from the line on which reset was released
            last_addr[i] = ((yy - ref_y[i]) / P_S[i]) * P_W[i] + (xx - P_X0[i]) / P_S[i];
            known[i] = 1'b1;
          end else begin
            known[i] = 1'b0;
          end
        end
      end
      e.chk[i]  = known[i];
      e.addr[i] = 18'(last_addr[i]);
    end
    e.av = avv;
    av_hist.push_back(avv);
    if (av_hist.size() > 8) void'(av_hist.pop_front());
    for (int i = 0; i < NI; i++) begin
      if (P_L[i] == 0) e.dv[i] = avv[i];
      else if (since_rst[i] >= P_L[i]) e.dv[i] = av_hist[av_hist.size() - 1 - P_L[i]][i];
      else e.dv[i] = 1'b0;
    end
    expq.push_back(e);
  endtask

  // Compressed raster: rows outside every window are skipped; optional 2-cycle reset
  task automatic frame(input int rx, input int ry);
    for (int yy = 0; yy < 54; yy++) begin
      if (yy > 7 && yy < 38) continue;
      for (int xx = 0; xx < 430; xx++) begin
        apply(xx, yy, (yy == ry) && (xx == rx || xx == rx + 1));
      end
    end
  endtask

  // Monitor: every registered output cycle pops one expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        mon_e = expq.pop_front();
        vectors++;
        for (int i = 0; i < NI; i++) begin
          if (mon_e.chk[i] && got_addr[i] !== mon_e.addr[i]) begin
            miscompares++;
            $display("FAIL addr inst%0d x=%0d y=%0d rst=%0b got %0d want %0d",
                     i, x, y, reset, got_addr[i], mon_e.addr[i]);
          end
          if (av_o[i] !== mon_e.av[i]) begin
            miscompares++;
            $display("FAIL addr_valid inst%0d x=%0d y=%0d rst=%0b got %0b want %0b",
                     i, x, y, reset, av_o[i], mon_e.av[i]);
          end
          if (dv_o[i] !== mon_e.dv[i]) begin
            miscompares++;
            $display("FAIL data_valid inst%0d x=%0d y=%0d rst=%0b got %0b want %0b",
                     i, x, y, reset, dv_o[i], mon_e.dv[i]);
          end
          if (fs_o[i] !== mon_e.fs[i]) begin
            miscompares++;
            $display("FAIL frame_start inst%0d x=%0d y=%0d rst=%0b got %0b want %0b",
                     i, x, y, reset, fs_o[i], mon_e.fs[i]);
          end
        end
      end
    end
  end

  initial begin
    int rx;
    int ry;
    reset = 1'b1;
    x = '0;
    y = '0;
    vectors = 0;
    miscompares = 0;
    for (int i = 0; i < NI; i++) begin
      synced[i] = 1'b0;
      ref_ok[i] = 1'b0;
      ref_y[i] = 0;
      known[i] = 1'b1;
      last_addr[i] = 0;
      since_rst[i] = 0;
    end

    repeat (3) apply(500, 500, 1'b1);
    frame(-1, -1);
    frame(200, 44);
    rx = int'($urandom_range(400, 0));
    ry = int'($urandom_range(50, 40));
    frame(rx, ry);
    frame(-1, -1);
    repeat (4) @(negedge clk);

    if (expq.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
